// File: rtl/counter_wrap_monitor.sv
// Watches an upstream 4-bit up-counter, counts its wraps while armed and raises
// irq once the (saturating) wrap count reaches a programmable threshold.
//
// state  | meaning
// IDLE   | monitoring disabled, wrap_count held at 0
// ARMED  | counting wraps, comparing against thresh
// ALERT  | threshold reached, irq high until acknowledged
// HOLD   | acknowledged, waiting for irq_ack to fall before re-arming
module counter_wrap_monitor #(
   parameter int WRAP_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        cnt_in,
   input  logic              ovf_in,
   input  logic              up_rst,
   input  logic              arm,
   input  logic [WRAP_W-1:0] thresh,
   input  logic              irq_ack,
   input  logic              sticky_clr,
   output logic              irq,
   output logic [WRAP_W-1:0] wrap_count,
   output logic              sticky_ovf,
   output logic [1:0]        state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_ALERT = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [WRAP_W-1:0] r_wrap_count;
   logic [WRAP_W-1:0] w_count_nxt;
   logic [WRAP_W-1:0] w_count_inc;
   logic [3:0]        r_prev_cnt;
   logic              r_sticky;
   logic              w_wrap;

   // A counter reset looks like a backwards step, so it never counts as a wrap.
   assign w_wrap      = !up_rst && (cnt_in < r_prev_cnt);
   assign w_count_inc = (w_wrap && (r_wrap_count != {WRAP_W{1'b1}}))
                        ? r_wrap_count + WRAP_W'(1) : r_wrap_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_wrap_count <= '0;
         r_prev_cnt   <= '0;
         r_sticky     <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_wrap_count <= w_count_nxt;
         r_prev_cnt   <= up_rst ? 4'd0 : cnt_in;
         if (ovf_in)
            r_sticky <= 1'b1;
         else if (sticky_clr)
            r_sticky <= 1'b0;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = w_count_inc;
      case (r_state)
         S_IDLE: begin
            w_count_nxt = '0;
            if (arm)
               w_state_nxt = S_ARMED;
         end
         S_ARMED: begin
            if ((thresh != '0) && (w_count_inc >= thresh))
               w_state_nxt = S_ALERT;
         end
         S_ALERT: begin
            if (irq_ack)
               w_state_nxt = S_HOLD;
         end
         S_HOLD: begin
            // Re-arm from a clean count; a wrap landing on this edge is dropped.
            if (!irq_ack) begin
               w_state_nxt = S_ARMED;
               w_count_nxt = '0;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_count_nxt = '0;
         end
      endcase
      if (!arm) begin
         w_state_nxt = S_IDLE;
         w_count_nxt = '0;
      end
   end

   assign irq        = (r_state == S_ALERT);
   assign wrap_count = r_wrap_count;
   assign sticky_ovf = r_sticky;
   assign state      = r_state;

endmodule

// File: doc/counter_wrap_monitor.md
COUNTER_WRAP_MONITOR -- requirements
Module: counter_wrap_monitor

Interface
REQ-001 Parameter WRAP_W, default 8: width of the wrap accumulator and threshold.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cnt_in  input  4  current value of the upstream 4-bit up-counter.
REQ-005 ovf_in  input  1  upstream overflow flag.
REQ-006 up_rst  input  1  upstream counter reset (same net that resets the counter).
REQ-007 arm  input  1  level; 1 = monitoring enabled.
REQ-008 thresh  input  WRAP_W  wrap count at which irq is raised; 0 = never raise.
REQ-009 irq_ack  input  1  interrupt acknowledge, level.
REQ-010 sticky_clr  input  1  single-cycle clear of sticky_ovf.
REQ-011 irq  output  1  interrupt request, high only in ALERT.
REQ-012 wrap_count  output  WRAP_W  wraps counted since last clear, saturating.
REQ-013 sticky_ovf  output  1  latched overflow status.
REQ-014 state  output  2  FSM encoding: IDLE=0, ARMED=1, ALERT=2, HOLD=3.

Function
REQ-015 The block SHALL register cnt_in each cycle into prev_cnt; when up_rst=1, prev_cnt SHALL load 0 instead.
REQ-016 A wrap event SHALL be declared in a cycle when up_rst=0 and cnt_in < prev_cnt (unsigned 4-bit compare).
REQ-017 When up_rst=1, no wrap event SHALL be declared that cycle, whatever cnt_in is.
REQ-018 In IDLE, wrap_count SHALL be held at 0.
REQ-019 In ARMED, ALERT and HOLD, each wrap event SHALL increment wrap_count by 1 at the same edge; the count SHALL saturate at 2^WRAP_W-1 and never wrap.
REQ-020 IDLE -> ARMED when arm=1; wrap_count SHALL be 0 on entry.
REQ-021 ARMED -> ALERT at the edge where the next value of wrap_count is >= thresh and thresh != 0.
REQ-022 ALERT -> HOLD at the first edge with irq_ack=1.
REQ-023 HOLD -> ARMED at the first edge with irq_ack=0; wrap_count SHALL load 0 at that edge, and a wrap event in that same cycle SHALL be discarded.
REQ-024 arm=0 SHALL force a transition to IDLE from any state at the next edge, with priority over all other transitions; wrap_count SHALL load 0.
REQ-025 irq SHALL be a decode of state == ALERT, so it is first high in the cycle after the edge that captured the threshold-reaching wrap (1-edge latency).
REQ-026 irq_ack seen in ARMED or IDLE SHALL be ignored.
REQ-027 sticky_ovf SHALL set at any edge with ovf_in=1 and clear at an edge with sticky_clr=1; if both are 1, set SHALL win.
REQ-028 sticky_ovf SHALL operate independently of FSM state, including IDLE.
REQ-029 A change in thresh SHALL take effect at the next compare; when ARMED with wrap_count already >= a new nonzero thresh, the FSM SHALL move to ALERT at the next edge.

Reset
REQ-030 reset=1 SHALL force state=IDLE, wrap_count=0, sticky_ovf=0, irq=0 and prev_cnt=0 at the next edge, overriding every other input, including mid-ALERT.
REQ-031 The first cycle after reset deasserts SHALL NOT declare a wrap event, because prev_cnt=0.

Verification
REQ-032 arm=1, thresh=3, cnt_in steps 0,2,..,14,0 three times -> wrap_count reaches 1,2,3; state=ALERT and irq=1 one cycle after the third 14->0 sample.
REQ-033 In ALERT, irq_ack=1 for 2 cycles then 0 -> HOLD after the first ack edge, irq=0; ARMED with wrap_count=0 after the ack falls.
REQ-034 cnt_in=10 then up_rst=1 with cnt_in=0 -> no increment; state unchanged.
REQ-035 WRAP_W=8, thresh=0, 300 wraps -> wrap_count saturates at 255, irq never asserts.
REQ-036 ovf_in=1 and sticky_clr=1 in the same cycle -> sticky_ovf=1; sticky_clr alone the next cycle -> 0.
REQ-037 Mid-ALERT, assert reset or drop arm for 1 cycle -> state=IDLE, irq=0, wrap_count=0 at the next edge.
